divisor8_ctrl: RTL
==================

DIVISOR8_CTRL -- requirements
Module: divisor8_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 A  input  8  unsigned dividend, captured on the accepting edge.
REQ-006 B  input  8  unsigned divisor, captured on the accepting edge.
REQ-007 Q  output  8  registered quotient of the last completed division.
REQ-008 R  output  8  registered remainder of the last completed division.
REQ-009 busy  output  1  high while in CALC.
REQ-010 done  output  1  one-cycle completion pulse, high only in DONE.
REQ-011 div_zero  output  1  divide-by-zero flag, registered with Q and R (see Configuration).

Function
REQ-012 SHALL implement 8-bit unsigned restoring division with exactly one subtrator8 instance, reused for every iteration.
REQ-013 subtrator8 S SHALL be taken as the 9-bit A-B; S[8]=1 means borrow, i.e. first operand < second operand.
REQ-014 FSM states SHALL be IDLE, CALC and DONE; 2-bit state register; unused encoding returns to IDLE on the next edge.
REQ-015 IDLE: start=1 on an edge -> latch A into quotient shift register qs, B into divisor register d; clear partial remainder pr and the 3-bit iteration counter; go to CALC.
REQ-016 CALC iteration, once per edge: t={pr[6:0],qs[7]}; subtractor computes t-d; success = pr[7] OR NOT S[8].
REQ-017 On success, pr<=S[7:0] and qs<={qs[6:0],1}; otherwise pr<=t and qs<={qs[6:0],0}.
REQ-018 pr[7] forcing success is mandatory: the true 9-bit trial exceeds d, and the 8-bit wrapped difference is exact because the result is < d.
REQ-019 After the 8th CALC edge (counter 7): Q<=final qs, R<=final pr, state<=DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Latency: start accepted at edge k -> busy=1 in cycles k+1..k+8 -> done=1 in cycle k+9 -> accepted again from edge k+10.
REQ-022 start in CALC or DONE SHALL be ignored; A and B changes after acceptance SHALL not affect the result.
REQ-023 Q, R and div_zero SHALL hold their values until the next completion; they never show intermediate values.
REQ-024 busy and done SHALL be decoded from state only, never both high.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, Q=0, R=0, div_zero=0, busy=0, done=0 and clear pr, qs, d and the counter, including mid-CALC (operation discarded).
REQ-026 After rst falls, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 Macro DIVISOR8_DIVZERO_EN SHALL select the divide-by-zero fast path.
REQ-028 Defined: B=0 at acceptance -> go directly to DONE on that edge with Q=8'hFF, R=A, div_zero=1; done in cycle k+1, no CALC cycles; any nonzero-B completion clears div_zero.
REQ-029 Undefined: B=0 runs the normal 8 iterations, naturally giving Q=8'hFF, R=A; div_zero tied to 0.

Verification
REQ-030 A=20, B=10, start 1 cycle -> busy cycles k+1..k+8, done in cycle k+9, Q=2, R=0.
REQ-031 A=100, B=200 -> Q=0, R=100; A=200, B=7 -> Q=28, R=4; A=255, B=1 -> Q=255, R=0; A=255, B=255 -> Q=1, R=0.
REQ-032 A=0, B=0 with DIVISOR8_DIVZERO_EN -> done in cycle k+1, Q=255, R=0, div_zero=1; without the macro -> done in cycle k+9, Q=255, R=0, div_zero=0.
REQ-033 Start A=20, B=10; at cycle k+3 pulse start with A=2, B=1 and change A and B -> ignored, result Q=2, R=0, single done pulse.
REQ-034 Start A=200, B=7; assert rst at cycle k+4 -> outputs 0 immediately, no done; restart A=2, B=1 -> Q=2, R=0.
REQ-035 start held high continuously, A=9, B=4 -> back-to-back operations, done every 10 cycles, Q=2, R=1 each time.

Source files
------------

// File: rtl/divisor8_ctrl_if.sv
// divisor8_ctrl_if -- request/result bundle for the 8-bit divider.
//   start    : request a division (sampled only while the divider is idle)
//   A, B     : unsigned dividend / divisor, captured on the accepting edge
//   Q, R     : registered quotient / remainder of the last completed division
//   busy     : high while iterations are running
//   done     : one-cycle completion pulse
//   div_zero : divide-by-zero flag, registered with Q and R
// master modport: requester side; slave modport: divider side.
interface divisor8_ctrl_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       div_zero;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, div_zero
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, div_zero
  );
endinterface

// File: rtl/divisor8_ctrl.sv
// divisor8_ctrl -- 8-bit unsigned restoring divider, one quotient bit per cycle,
// using a single shared subtractor for every iteration.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : divisor8_ctrl_if.slave (start/A/B in, Q/R/busy/done/div_zero out)
// Build option: define DIVISOR8_DIVZERO_EN to finish a B=0 request straight away
// (Q=8'hFF, R=A, div_zero=1). Without it B=0 runs the normal eight iterations,
// which already yield Q=8'hFF, R=A, and div_zero stays 0.

module subtrator8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [8:0] S   // S[8]=1 means borrow (A < B)
);
  assign S = {1'b0, A} - {1'b0, B};
endmodule

module divisor8_ctrl (
  input  logic             clk,
  input  logic             rst,
  divisor8_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] qs_q, qs_d;     // dividend shifting out / quotient shifting in
  logic [7:0] pr_q, pr_d;     // partial remainder
  logic [7:0] d_q, d_d;       // divisor
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;

  logic [7:0] t;
  logic [8:0] s;
  logic       success;

  assign t = {pr_q[6:0], qs_q[7]};

  subtrator8 u_sub (
    .A (t),
    .B (d_q),
    .S (s)
  );

  // pr[7] set means the true 9-bit trial value exceeds d, so the subtraction
  // must succeed; the wrapped 8-bit difference is still exact since it is < d.
  assign success = pr_q[7] | ~s[8];

`ifdef DIVISOR8_DIVZERO_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    qs_d    = qs_q;
    pr_d    = pr_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIVISOR8_DIVZERO_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          qs_d    = bus.A;
          d_d     = bus.B;
          pr_d    = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIVISOR8_DIVZERO_EN
          if (bus.B == '0) begin
            q_d     = '1;
            r_d     = bus.A;
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 3'd1;
        qs_d  = {qs_q[6:0], success};
        pr_d  = success ? s[7:0] : t;
        if (cnt_q == 3'd7) begin
          q_d     = qs_d;
          r_d     = pr_d;
`ifdef DIVISOR8_DIVZERO_EN
          dz_d    = 1'b0;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      qs_q    <= '0;
      pr_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef DIVISOR8_DIVZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      qs_q    <= qs_d;
      pr_q    <= pr_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef DIVISOR8_DIVZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
`ifdef DIVISOR8_DIVZERO_EN
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif
endmodule
